keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Synthesizable 4x4 matrix-keypad responder: the keypad side of the row-scan/column-sense protocol driven by `keypad_scan`. It answers row strobes on its column outputs as if one key were physically pressed, including contact bounce on press and release. It sits on the test FPGA in place of the physical pad, so the scan, decode and display chain can be exercised hands-free from a request interface.

## Interface
Parameters:
- BOUNCE_CYCLES, 8: clocks of pseudo-random contact chatter on press and on release. Legal range ≥1.
- GAP_CYCLES, 16: clocks of guaranteed open contact after release, before the next request is accepted. Legal range ≥1.

Ports:
- clk  in  1  system clock, same domain as the scanner clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  1  press request valid.
- req_key  in  4  key code; row = req_key[3:2], column = req_key[1:0].
- req_hold  in  16  stable-contact duration in clocks; 0 is treated as 1.
- req_ready  out  1  high only in IDLE.
- abort  in  1  synchronous cancel of the current press.
- row_scn  in  4  row strobes from the scanner, active-low.
- col_out  out  4  column sense lines to the scanner, active-low; idle 4'b1111.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-clock pulse when a press sequence finishes, including aborted ones.

## Operation
- States: IDLE, PBOUNCE, HOLD, RBOUNCE, GAP.
- IDLE: contact=0, req_ready=1. On req_valid=1 at a rising edge:
  - latch key_r←req_key and hold_r←max(req_hold,1);
  - load cnt←BOUNCE_CYCLES-1;
  - go to PBOUNCE.
- PBOUNCE: contact=lfsr[0]. When cnt==0, load cnt←hold_r-1 and go to HOLD; otherwise decrement cnt.
- HOLD: contact=1. When cnt==0, load cnt←BOUNCE_CYCLES-1 and go to RBOUNCE; otherwise decrement.
- RBOUNCE: contact=lfsr[0]. When cnt==0, load cnt←GAP_CYCLES-1 and go to GAP; otherwise decrement.
- GAP: contact=0. When cnt==0, go to IDLE and assert done for that one transition clock; otherwise decrement.
- abort=1 in PBOUNCE, HOLD or RBOUNCE: next state GAP with cnt←GAP_CYCLES-1, and contact drops to 0 the following cycle.
- abort in IDLE or GAP: ignored.
- abort and req_valid together in IDLE: the request is accepted.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1;
  - seed 8'hA5 on reset;
  - advances every clock regardless of state;
  - never reaches all-zero.
- col_out is combinational from registered contact and key_r, and the live row_scn:
  - if contact=1 and row_scn[key_r[3:2]]==0, col_out = 4'b1111 with bit key_r[1:0] cleared;
  - otherwise col_out = 4'b1111.
- Other rows being low simultaneously does not matter; only the target row is examined.
- req_key and req_hold are sampled only at acceptance. Changes afterwards have no effect.

## Timing
- Reset (rst_n=0 at an edge) puts the block in this state, from any state including mid-press:
  - state=IDLE, contact=0, cnt=0, key_r=0, hold_r=1, lfsr=8'hA5;
  - req_ready=1, busy=0, done=0, col_out=4'b1111 immediately after that edge.
- Request accepted at edge T:
  - busy=1 and PBOUNCE from T+1;
  - PBOUNCE occupies BOUNCE_CYCLES clocks;
  - HOLD occupies exactly hold_r clocks of contact=1;
  - RBOUNCE occupies BOUNCE_CYCLES clocks;
  - GAP occupies GAP_CYCLES clocks.
- done=1 on the single clock in which IDLE is re-entered, i.e. T+1+2·BOUNCE_CYCLES+hold_r+GAP_CYCLES.
- From that same clock: req_ready=1 and busy=0.
- Back-to-back: a request held valid through done is accepted on the first IDLE clock. There are no dead cycles beyond GAP.
- col_out follows row_scn changes with zero clock latency; it follows contact changes with one register stage.

## Test plan
- Reset mid-HOLD, with key 4'h5 and row_scn=4'b1101 → col_out=4'b1111, req_ready=1, busy=0, done=0 on the first clock after the reset edge.
- Key 4'h9, hold=100, BOUNCE_CYCLES=8, GAP_CYCLES=16, row_scn held at 4'b1011:
  - col_out=4'b1101 for exactly 100 consecutive HOLD clocks;
  - done rises exactly 133 clocks after acceptance.
- Key 4'hF while row_scn cycles 1110→1101→1011→0111 every clock during HOLD → col_out=4'b0111 only while row_scn=4'b0111, and 4'b1111 otherwise.
- req_hold=0 → HOLD lasts exactly 1 clock.
- abort asserted on the 3rd HOLD clock → contact=0 the next clock, then GAP_CYCLES clocks, then a done pulse.
- Two requests with req_valid kept high (key 4'h0 then key 4'hA) → the second is accepted on the same clock that done pulses for the first, and its column/row mapping is col_out=4'b1011 while row_scn=4'b1011.

Source files
------------

// File: rtl/keypad_emulator.sv
// Keypad-side responder for a 4x4 row-scan/column-sense matrix.
// It presents one virtual key press, with LFSR-driven contact bounce on press and release.
`timescale 1ns/1ps
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_key,
    input  logic [15:0] req_hold,
    output logic        req_ready,
    input  logic        abort,
    input  logic [3:0]  row_scn,
    output logic [3:0]  col_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PBOUNCE = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RBOUNCE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

    // Taps x^8+x^6+x^5+x^4+1; from a nonzero seed the sequence never hits zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  key_q, key_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        contact_q, contact_d;
    logic        done_q, done_d;

    // Next-state, counter and latch logic for the press sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        key_d   = key_q;
        done_d  = 1'b0;
        lfsr_d  = lfsr_next(lfsr_q);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    key_d   = req_key;
                    hold_d  = (req_hold == 16'd0) ? 16'd1 : req_hold;
                    cnt_d   = BOUNCE_LOAD;
                    state_d = ST_PBOUNCE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PBOUNCE: begin
                if (abort) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (cnt_q == 16'd0) begin
                    cnt_d   = hold_q - 16'd1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (cnt_q == 16'd0) begin
                    cnt_d   = BOUNCE_LOAD;
                    state_d = ST_RBOUNCE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RBOUNCE: begin
                if (abort || (cnt_q == 16'd0)) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Contact is decoded from the next state so the registered value lines up with state_q.
    always_comb begin
        contact_d = 1'b0;
        case (state_d)
            ST_PBOUNCE: contact_d = lfsr_q[0];
            ST_HOLD:    contact_d = 1'b1;
            ST_RBOUNCE: contact_d = lfsr_q[0];
            default:    contact_d = 1'b0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            hold_q    <= 16'd1;
            key_q     <= 4'd0;
            lfsr_q    <= 8'hA5;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            key_q     <= key_d;
            lfsr_q    <= lfsr_d;
            contact_q <= contact_d;
            done_q    <= done_d;
        end
    end

    // Only the target row is examined; the live strobe passes through with no register.
    always_comb begin
        if (contact_q && (row_scn[key_q[3:2]] == 1'b0)) begin
            col_out = 4'b1111 & ~(4'b0001 << key_q[1:0]);
        end else begin
            col_out = 4'b1111;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (BOUNCE_CYCLES=8, GAP_CYCLES=16).
// Inputs are driven and outputs sampled on the falling edge; n counts edges since acceptance.
`timescale 1ns/1ps
module tb_keypad_emulator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_key;
    logic [15:0] req_hold;
    logic        req_ready;
    logic        abort;
    logic [3:0]  row_scn;
    logic [3:0]  col_out;
    logic        busy;
    logic        done;

    int total;
    int bad;
    int n;

    keypad_emulator #(.BOUNCE_CYCLES(8), .GAP_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_key   (req_key),
        .req_hold  (req_hold),
        .req_ready (req_ready),
        .abort     (abort),
        .row_scn   (row_scn),
        .col_out   (col_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        n = n + 1;
    endtask

    task automatic send(input logic [3:0] k, input logic [15:0] h);
        req_key   = k;
        req_hold  = h;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic wait_done(input int limit);
        while (done !== 1'b1 && n < limit) tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        row_scn = 4'b0000;
        repeat (3) @(negedge clk);
        total++; if (col_out !== 4'b1111) begin bad++; $display("FAIL por_col: got %b want 1111", col_out); end
        total++; if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL por_flags: got ready=%b busy=%b done=%b want 1 0 0", req_ready, busy, done);
        end
        rst_n = 1'b1;
        row_scn = 4'b1111;
        @(negedge clk);
        send(4'h5, 16'd50);
        run_to(15);
        row_scn = 4'b1101;
        #1;
        total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL pre_reset_hold_col: got %b want 1101", col_out); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (col_out !== 4'b1111) begin bad++; $display("FAIL midhold_reset_col: got %b want 1111", col_out); end
        total++; if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midhold_reset_flags: got ready=%b busy=%b done=%b want 1 0 0", req_ready, busy, done);
        end
        rst_n   = 1'b1;
        row_scn = 4'b1111;
        @(negedge clk);
    endtask

    task automatic test_long_hold();
        int hits = 0;
        int gap_err = 0;
        row_scn = 4'b1011;
        send(4'h9, 16'd100);
        total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL accept_busy: got busy=%b ready=%b want 1 0", busy, req_ready);
        end
        while (done !== 1'b1 && n < 140) begin
            if (n >= 9 && n <= 108 && col_out === 4'b1101) hits++;
            if (n >= 117 && col_out !== 4'b1111) gap_err++;
            tick();
        end
        total++; if (hits != 100) begin bad++; $display("FAIL hold_run: got %0d hold clocks want 100", hits); end
        total++; if (gap_err != 0) begin bad++; $display("FAIL gap_open: got %0d closed gap clocks want 0", gap_err); end
        total++; if (done !== 1'b1 || n != 133) begin bad++; $display("FAIL done_latency: got done=%b at %0d want 1 at 133", done, n); end
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL done_flags: got ready=%b busy=%b want 1 0", req_ready, busy);
        end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done); end
    endtask

    task automatic test_row_cycle();
        logic [3:0] pats [4];
        logic [3:0] exp;
        pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
        send(4'hF, 16'd20);
        run_to(9);
        for (int i = 0; i < 20; i++) begin
            row_scn = pats[i % 4];
            #1;
            exp = (row_scn == 4'b0111) ? 4'b0111 : 4'b1111;
            total++; if (col_out !== exp) begin bad++; $display("FAIL row_cycle[%0d]: got %b want %b", i, col_out, exp); end
            tick();
        end
        row_scn = 4'b1111;
        wait_done(100);
        total++; if (done !== 1'b1 || n != 53) begin bad++; $display("FAIL row_cycle_done: got done=%b at %0d want 1 at 53", done, n); end
        tick();
    endtask

    task automatic test_hold_zero();
        row_scn = 4'b1101;
        send(4'h6, 16'd0);
        run_to(9);
        #1;
        total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL hold0_col: got %b want 1011", col_out); end
        wait_done(100);
        total++; if (done !== 1'b1 || n != 34) begin bad++; $display("FAIL hold0_done: got done=%b at %0d want 1 at 34", done, n); end
        tick();
    endtask

    task automatic test_abort();
        row_scn = 4'b1101;
        send(4'h5, 16'd50);
        run_to(11);
        total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL abort_pre_col: got %b want 1101", col_out); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (col_out !== 4'b1111 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_drop: got col=%b busy=%b want 1111 1", col_out, busy);
        end
        wait_done(100);
        total++; if (done !== 1'b1 || n != 28) begin bad++; $display("FAIL abort_done: got done=%b at %0d want 1 at 28", done, n); end
        tick();
        abort = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got ready=%b busy=%b want 1 0", req_ready, busy);
        end
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_ignored_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        row_scn   = 4'b1110;
        req_key   = 4'h0;
        req_hold  = 16'd5;
        req_valid = 1'b1;
        @(negedge clk);
        n = 1;
        req_key  = 4'hA;
        req_hold = 16'd3;
        run_to(9);
        #1;
        total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL b2b_first_col: got %b want 1110", col_out); end
        wait_done(60);
        total++; if (done !== 1'b1 || n != 38 || req_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_first_done: got done=%b ready=%b at %0d want 1 1 at 38", done, req_ready, n);
        end
        tick();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        req_valid = 1'b0;
        n = 1;
        row_scn = 4'b1011;
        run_to(9);
        #1;
        total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL b2b_second_col: got %b want 1011", col_out); end
        wait_done(80);
        total++; if (done !== 1'b1 || n != 36) begin bad++; $display("FAIL b2b_second_done: got done=%b at %0d want 1 at 36", done, n); end
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        n         = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_key   = 4'h0;
        req_hold  = 16'd0;
        abort     = 1'b0;
        row_scn   = 4'b1111;
        test_reset();
        test_long_hold();
        test_row_cycle();
        test_hold_zero();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
